// File: rtl/pc_gen.sv
// Fetch-side program counter: handshake to fetch, trap/redirect steering,
// debug halt/resume, misaligned-target flagging and an accepted-fetch count.
module pc_gen #(
  parameter int unsigned             XLEN         = 32,
  parameter logic [XLEN-1:0]         RESET_VECTOR = '0,
  parameter int unsigned             INC          = 4,
  parameter int unsigned             ALIGN_BITS   = 2,
  parameter int unsigned             CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_ready,
  output logic             pc_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             halted,
  output logic             misaligned,
  output logic [XLEN-1:0]  misaligned_addr,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] AMASK =
    XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INC);

  state_t state;

  logic fire;
  logic live;
  logic bad_tgt;
  logic take_trap;
  logic take_redir;
  logic take_mis;
  logic take_inc;

  assign fire    = pc_valid & fetch_ready;
  assign live    = (state != BOOT);
  assign bad_tgt = |(redirect_target & AMASK);

  // Priority flattened into exclusive selects: trap, redirect, increment.
  always_comb begin
    take_trap  = live & trap_valid;
    take_redir = live & ~trap_valid & redirect_valid & ~bad_tgt;
    take_mis   = live & ~trap_valid & redirect_valid & bad_tgt;
    take_inc   = ~trap_valid & ~redirect_valid & fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= BOOT;
      pc              <= RESET_VECTOR;
      pc_valid        <= 1'b0;
      halted          <= 1'b0;
      misaligned      <= 1'b0;
      misaligned_addr <= '0;
      fetch_count     <= '0;
    end else begin
      misaligned <= 1'b0;

      unique case (1'b1)
        take_trap:  pc <= trap_target;
        take_redir: pc <= redirect_target;
        take_mis: begin
          misaligned      <= 1'b1;
          misaligned_addr <= redirect_target;
        end
        take_inc:   pc <= pc + STEP;
        default:    pc <= pc;
      endcase

      if (fire)
        fetch_count <= fetch_count + 1'b1;

      unique case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALTED;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        HALTED: begin
          if (resume_req && !halt_req) begin
            state    <= RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: hand-computed pc, count and status values
// checked on the falling edge after each rising edge.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        fetch_ready;
  logic        pc_valid;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume_req;
  logic        halted;
  logic        misaligned;
  logic [31:0] misaligned_addr;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  pc_gen dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_ready     (fetch_ready),
    .pc_valid        (pc_valid),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .halt_req        (halt_req),
    .resume_req      (resume_req),
    .halted          (halted),
    .misaligned      (misaligned),
    .misaligned_addr (misaligned_addr),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic st(input string tag, input logic [31:0] epc,
                    input logic ev, input logic eh,
                    input logic [31:0] ecnt);
    chk({tag, ".pc"}, 64'(pc), 64'(epc));
    chk({tag, ".valid"}, 64'(pc_valid), 64'(ev));
    chk({tag, ".halted"}, 64'(halted), 64'(eh));
    chk({tag, ".count"}, 64'(fetch_count), 64'(ecnt));
  endtask

  initial begin
    reset           = 1'b1;
    fetch_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_target     = '0;
    halt_req        = 1'b0;
    resume_req      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    st("rst", 32'h0, 1'b0, 1'b0, 32'd0);
    chk("rst.mis", 64'(misaligned), 64'd0);
    chk("rst.maddr", 64'(misaligned_addr), 64'd0);

    reset       = 1'b0;
    fetch_ready = 1'b1;
    st("boot", 32'h0, 1'b0, 1'b0, 32'd0);
    tick(); st("run0", 32'h0, 1'b1, 1'b0, 32'd0);
    tick(); st("run1", 32'h4, 1'b1, 1'b0, 32'd1);
    tick(); st("run2", 32'h8, 1'b1, 1'b0, 32'd2);
    tick(); st("run3", 32'hC, 1'b1, 1'b0, 32'd3);
    tick(); st("run4", 32'h10, 1'b1, 1'b0, 32'd4);

    fetch_ready     = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick(); st("redir", 32'h200, 1'b1, 1'b0, 32'd4);

    fetch_ready     = 1'b1;
    trap_valid      = 1'b1;
    trap_target     = 32'h80;
    redirect_target = 32'h300;
    tick(); st("trap", 32'h80, 1'b1, 1'b0, 32'd5);
    trap_valid  = 1'b0;
    fetch_ready = 1'b0;

    redirect_target = 32'h102;
    tick(); st("mis", 32'h80, 1'b1, 1'b0, 32'd5);
    chk("mis.pulse", 64'(misaligned), 64'd1);
    chk("mis.addr", 64'(misaligned_addr), 64'h102);
    redirect_valid = 1'b0;
    tick();
    chk("mis.clear", 64'(misaligned), 64'd0);
    chk("mis.hold", 64'(misaligned_addr), 64'h102);

    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick(); st("to40", 32'h40, 1'b1, 1'b0, 32'd5);
    redirect_valid = 1'b0;

    halt_req = 1'b1;
    tick(); st("halt", 32'h40, 1'b0, 1'b1, 32'd5);
    halt_req        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h500;
    tick(); st("hredir", 32'h500, 1'b0, 1'b1, 32'd5);
    redirect_target = 32'h503;
    tick(); st("hmis", 32'h500, 1'b0, 1'b1, 32'd5);
    chk("hmis.pulse", 64'(misaligned), 64'd1);
    chk("hmis.addr", 64'(misaligned_addr), 64'h503);
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    tick(); st("hnofire", 32'h500, 1'b0, 1'b1, 32'd5);
    halt_req   = 1'b1;
    resume_req = 1'b1;
    tick(); st("hboth", 32'h500, 1'b0, 1'b1, 32'd5);
    halt_req = 1'b0;
    tick(); st("resume", 32'h500, 1'b1, 1'b0, 32'd5);
    resume_req = 1'b0;
    tick(); st("rfire", 32'h504, 1'b1, 1'b0, 32'd6);

    halt_req = 1'b1;
    tick(); st("haltfire", 32'h508, 1'b0, 1'b1, 32'd7);
    halt_req   = 1'b0;
    resume_req = 1'b1;
    tick(); st("resume2", 32'h508, 1'b1, 1'b0, 32'd7);
    resume_req = 1'b0;

    fetch_ready     = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick(); st("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd7);
    redirect_valid = 1'b0;
    fetch_ready    = 1'b1;
    tick(); st("wrap", 32'h0, 1'b1, 1'b0, 32'd8);
    tick(); st("wrap1", 32'h4, 1'b1, 1'b0, 32'd9);

    @(posedge clk);
    #2 reset = 1'b1;
    #1 st("async", 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    st("boot2", 32'h0, 1'b0, 1'b0, 32'd0);
    tick(); st("run2_0", 32'h0, 1'b1, 1'b0, 32'd0);
    tick(); st("run2_1", 32'h4, 1'b1, 1'b0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
